// File: rtl/jpeg_dct_channel_scheduler.sv
// jpeg_dct_channel_scheduler: time-shares one DCT pipeline among Y, Cb and Cr
// in strict MCU order, and tags each issued block so results return labelled.
// Optional feature: define JPEG_SCHED_STALL_CNT_EN to add the stall_count output.
module jpeg_dct_channel_scheduler #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PIXEL_COUNT = 64,
    parameter int unsigned TAG_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              y_valid,
    output logic                              y_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] y_block,
    input  logic                              cb_valid,
    output logic                              cb_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cb_block,
    input  logic                              cr_valid,
    output logic                              cr_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cr_block,
    output logic                              dct_in_valid,
    input  logic                              dct_in_ready,
    output logic [DATA_WIDTH*PIXEL_COUNT-1:0] dct_in_block,
    input  logic                              dct_out_valid,
    output logic                              dct_out_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] dct_out_block,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH*PIXEL_COUNT-1:0] out_block,
    output logic [1:0]                        out_chan,
    output logic [15:0]                       mcu_count,
    output logic                              protocol_err
`ifdef JPEG_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_count
`endif
);

    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SEL_Y  = 2'd0,
        SEL_CB = 2'd1,
        SEL_CR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_sel_valid;
    logic               w_issue;
    logic               w_pop;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count_nxt;

    logic [1:0]         r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic [15:0]        r_mcu_count;
    logic               r_protocol_err;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= SEL_Y;
        else       r_state <= w_state_nxt;
    end

    // Channel select mux, handshake gating and next-state; full blocks issue
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_valid  = 1'b0;
        dct_in_block = '0;
        y_ready      = 1'b0;
        cb_ready     = 1'b0;
        cr_ready     = 1'b0;
        case (r_state)
            SEL_Y: begin
                w_sel_valid  = y_valid;
                dct_in_block = y_block;
                y_ready      = dct_in_ready & ~r_full & ~reset;
            end
            SEL_CB: begin
                w_sel_valid  = cb_valid;
                dct_in_block = cb_block;
                cb_ready     = dct_in_ready & ~r_full & ~reset;
            end
            SEL_CR: begin
                w_sel_valid  = cr_valid;
                dct_in_block = cr_block;
                cr_ready     = dct_in_ready & ~r_full & ~reset;
            end
            default: w_state_nxt = SEL_Y;
        endcase
        dct_in_valid = w_sel_valid & ~r_full & ~reset;
        w_issue      = dct_in_valid & dct_in_ready;
        if (w_issue) begin
            case (r_state)
                SEL_Y:   w_state_nxt = SEL_CB;
                SEL_CB:  w_state_nxt = SEL_CR;
                default: w_state_nxt = SEL_Y;
            endcase
        end
    end

    // Zero-latency return path; head tag labels the result, 3 when no tag is held
    assign w_empty       = (r_count == '0);
    assign w_pop         = dct_out_valid & out_ready & ~w_empty;
    assign out_valid     = dct_out_valid;
    assign out_block     = dct_out_block;
    assign dct_out_ready = out_ready;
    assign out_chan      = w_empty ? 2'd3 : r_tag_mem[r_rd_ptr];
    assign mcu_count     = r_mcu_count;
    assign protocol_err  = r_protocol_err;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_issue, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Tag storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_issue) r_tag_mem[r_wr_ptr] <= r_state;
    end

    // Tag FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_issue) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(TAG_DEPTH));
        end
    end

    // MCU counter: one count per Cr issue, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (reset)                           r_mcu_count <= '0;
        else if (w_issue && r_state == SEL_CR) r_mcu_count <= r_mcu_count + 16'd1;
    end

    // Sticky flag for a result arriving with no outstanding tag
    always_ff @(posedge clk) begin
        if (reset)                         r_protocol_err <= 1'b0;
        else if (dct_out_valid && w_empty) r_protocol_err <= 1'b1;
    end

`ifdef JPEG_SCHED_STALL_CNT_EN
    logic [31:0] r_stall_count;
    assign stall_count = r_stall_count;

    // Saturating count of cycles where the selected channel waits
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= '0;
        else if (w_sel_valid && !w_issue && r_stall_count != 32'hFFFF_FFFF)
            r_stall_count <= r_stall_count + 32'd1;
    end
`else
    // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_jpeg_dct_channel_scheduler.sv
// Directed bench for jpeg_dct_channel_scheduler: issue order, tag FIFO,
// return labelling, protocol error, mid-operation reset and counter wrap.
module tb_jpeg_dct_channel_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned PC = 64;
    localparam int unsigned BW = DW * PC;

    logic          clk = 1'b0;
    logic          reset;
    logic          y_valid, cb_valid, cr_valid;
    logic          y_ready, cb_ready, cr_ready;
    logic [BW-1:0] y_block, cb_block, cr_block;
    logic          dct_in_valid, dct_in_ready;
    logic [BW-1:0] dct_in_block;
    logic          dct_out_valid, dct_out_ready;
    logic [BW-1:0] dct_out_block;
    logic          out_valid, out_ready;
    logic [BW-1:0] out_block;
    logic [1:0]    out_chan;
    logic [15:0]   mcu_count;
    logic          protocol_err;
`ifdef JPEG_SCHED_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    jpeg_dct_channel_scheduler #(
        .DATA_WIDTH (DW),
        .PIXEL_COUNT(PC),
        .TAG_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_block      (y_block),
        .cb_valid     (cb_valid),
        .cb_ready     (cb_ready),
        .cb_block     (cb_block),
        .cr_valid     (cr_valid),
        .cr_ready     (cr_ready),
        .cr_block     (cr_block),
        .dct_in_valid (dct_in_valid),
        .dct_in_ready (dct_in_ready),
        .dct_in_block (dct_in_block),
        .dct_out_valid(dct_out_valid),
        .dct_out_ready(dct_out_ready),
        .dct_out_block(dct_out_block),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_block    (out_block),
        .out_chan     (out_chan),
        .mcu_count    (mcu_count),
        .protocol_err (protocol_err)
`ifdef JPEG_SCHED_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed low word %0h expected low word %0h", tag, obs[31:0], exp[31:0]);
        end
    endtask

    initial begin
        logic [BW-1:0] blk_a, blk_b, blk_c, res;
        logic [1:0]    exp_chan [4];
        blk_a = {PC{32'hA000_0001}};
        blk_b = {PC{32'hB000_0002}};
        blk_c = {PC{32'hC000_0003}};
        exp_chan = '{2'd1, 2'd2, 2'd0, 2'd1};

        reset = 1'b1;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        y_block = blk_a; cb_block = blk_b; cr_block = blk_c;
        dct_in_ready = 1'b0; dct_out_valid = 1'b0; dct_out_block = '0; out_ready = 1'b0;
        tick; tick;

        // Readys and dct_in_valid forced low while reset is held
        y_valid = 1'b1; cr_valid = 1'b1; dct_in_ready = 1'b1; #1;
        check("rst_y_ready", 32'(y_ready), 32'd0);
        check("rst_cr_ready", 32'(cr_ready), 32'd0);
        check("rst_dct_in_valid", 32'(dct_in_valid), 32'd0);
        y_valid = 1'b0; cr_valid = 1'b0; reset = 1'b0; #1;
        check("rst_mcu", 32'(mcu_count), 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd3);
        check("rst_state", 32'(dut.r_state), 32'd0);
`ifdef JPEG_SCHED_STALL_CNT_EN
        check("rst_stall", stall_count, 32'd0);
`endif

        // Strict ordering: Cb alone cannot issue while Y is selected
        cb_valid = 1'b1; #1;
        check("ord_dct_in_valid", 32'(dct_in_valid), 32'd0);
        check("ord_cb_ready", 32'(cb_ready), 32'd0);
        check("ord_y_ready", 32'(y_ready), 32'd1);
        tick; tick; tick; #1;
        check("ord_state", 32'(dut.r_state), 32'd0);
        check("ord_dct_in_valid2", 32'(dct_in_valid), 32'd0);
`ifdef JPEG_SCHED_STALL_CNT_EN
        check("ord_stall", stall_count, 32'd0);
`endif
        cb_valid = 1'b0;

        // In-order issue Y, Cb, Cr on consecutive cycles
        y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1; #1;
        check("io_valid_y", 32'(dct_in_valid), 32'd1);
        check_blk("io_blk_y", dct_in_block, blk_a);
        check("io_y_ready", 32'(y_ready), 32'd1);
        check("io_cb_ready0", 32'(cb_ready), 32'd0);
        tick; #1;
        check_blk("io_blk_cb", dct_in_block, blk_b);
        check("io_cb_ready", 32'(cb_ready), 32'd1);
        check("io_y_ready0", 32'(y_ready), 32'd0);
        tick; #1;
        check_blk("io_blk_cr", dct_in_block, blk_c);
        check("io_cr_ready", 32'(cr_ready), 32'd1);
        check("io_mcu0", 32'(mcu_count), 32'd0);
        tick; #1;
        check("io_mcu1", 32'(mcu_count), 32'd1);
        check("io_state", 32'(dut.r_state), 32'd0);
        check("io_head", 32'(out_chan), 32'd0);

        // Fourth issue fills the 4-entry tag FIFO
        check("full_pre_valid", 32'(dct_in_valid), 32'd1);
        tick; #1;
        check("full_dct_in_valid", 32'(dct_in_valid), 32'd0);
        check("full_y_ready", 32'(y_ready), 32'd0);
        check("full_cb_ready", 32'(cb_ready), 32'd0);
        check("full_cr_ready", 32'(cr_ready), 32'd0);
        check("full_state", 32'(dut.r_state), 32'd1);
        tick;
        res = {PC{32'hD000_0000}};
        dct_out_valid = 1'b1; out_ready = 1'b1; dct_out_block = res; #1;
        check("pop_out_valid", 32'(out_valid), 32'd1);
        check("pop_dct_out_ready", 32'(dct_out_ready), 32'd1);
        check("pop_chan", 32'(out_chan), 32'd0);
        check_blk("pop_blk", out_block, res);
        check("pop_full_blocks", 32'(dct_in_valid), 32'd0);
        tick;
        dct_out_valid = 1'b0; #1;
        check("reen_valid", 32'(dct_in_valid), 32'd1);
        check("reen_cb_ready", 32'(cb_ready), 32'd1);
        check_blk("reen_blk", dct_in_block, blk_b);
`ifdef JPEG_SCHED_STALL_CNT_EN
        check("full_stall", stall_count, 32'd2);
`endif
        tick;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0; #1;
        check("refill_valid", 32'(dct_in_valid), 32'd0);
        check("refill_state", 32'(dut.r_state), 32'd2);
        check("refill_mcu", 32'(mcu_count), 32'd1);

        // Drain: results labelled in issue order
        for (int k = 0; k < 4; k++) begin
            res = {PC{32'hD000_0010 | 32'(k)}};
            dct_out_valid = 1'b1; dct_out_block = res; #1;
            check($sformatf("drain_chan%0d", k), 32'(out_chan), 32'(exp_chan[k]));
            check_blk($sformatf("drain_blk%0d", k), out_block, res);
            tick;
        end
        dct_out_valid = 1'b0; #1;
        check("drain_empty", 32'(out_chan), 32'd3);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Simultaneous push and pop keeps occupancy
        cr_valid = 1'b1; #1;
        check_blk("pp_blk_cr", dct_in_block, blk_c);
        tick;
        cr_valid = 1'b0; #1;
        check("pp_mcu2", 32'(mcu_count), 32'd2);
        check("pp_head_cr", 32'(out_chan), 32'd2);
        y_valid = 1'b1; dct_out_valid = 1'b1; #1;
        check("pp_issue", 32'(dct_in_valid), 32'd1);
        tick;
        y_valid = 1'b0; dct_out_valid = 1'b0; #1;
        check("pp_head_y", 32'(out_chan), 32'd0);
        check("pp_state", 32'(dut.r_state), 32'd1);
        dct_out_valid = 1'b1;
        tick;
        dct_out_valid = 1'b0; #1;
        check("pp_empty", 32'(out_chan), 32'd3);
        check("pp_err", 32'(protocol_err), 32'd0);

        // Spurious result with empty FIFO
        dct_out_valid = 1'b1; #1;
        check("sp_chan", 32'(out_chan), 32'd3);
        check("sp_err_before", 32'(protocol_err), 32'd0);
        tick;
        dct_out_valid = 1'b0; #1;
        check("sp_err", 32'(protocol_err), 32'd1);
        cb_valid = 1'b1;
        tick;
        cb_valid = 1'b0; #1;
        check("sp_no_pop", 32'(out_chan), 32'd1);
        cr_valid = 1'b1; tick;
        cr_valid = 1'b0; y_valid = 1'b1; tick;
        y_valid = 1'b0; cb_valid = 1'b1; tick;
        cb_valid = 1'b0; #1;
        check("mid_mcu3", 32'(mcu_count), 32'd3);
        check("mid_state", 32'(dut.r_state), 32'd2);
        dct_out_valid = 1'b1; #1;
        check("mid_pop1", 32'(out_chan), 32'd1);
        tick; #1;
        check("mid_pop2", 32'(out_chan), 32'd2);
        tick;
        dct_out_valid = 1'b0; #1;
        check("mid_head", 32'(out_chan), 32'd0);
        check("sp_err_sticky", 32'(protocol_err), 32'd1);

        // Reset mid-operation: 2 tags outstanding, FSM in SEL_CR
        cr_valid = 1'b1; reset = 1'b1; #1;
        check("mr_cr_ready", 32'(cr_ready), 32'd0);
        check("mr_dct_in_valid", 32'(dct_in_valid), 32'd0);
        tick;
        reset = 1'b0; cr_valid = 1'b0; #1;
        check("mr_state", 32'(dut.r_state), 32'd0);
        check("mr_empty", 32'(out_chan), 32'd3);
        check("mr_mcu", 32'(mcu_count), 32'd0);
        check("mr_err", 32'(protocol_err), 32'd0);

        // Counter wrap from preloaded 0xFFFF
        force dut.r_mcu_count = 16'hFFFF;
        tick;
        release dut.r_mcu_count; #1;
        check("wrap_pre", 32'(mcu_count), 32'h0000_FFFF);
        out_ready = 1'b0;
        y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1;
        tick; tick; tick;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0; #1;
        check("wrap_mcu", 32'(mcu_count), 32'd0);
        check("wrap_state", 32'(dut.r_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_dct_channel_scheduler.md
JPEG_DCT_CHANNEL_SCHEDULER -- requirements
Module: jpeg_dct_channel_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: bit width of one coefficient or sample.
REQ-002 The block SHALL have parameter PIXEL_COUNT, default 64: samples per 8x8 block.
REQ-003 The block SHALL have parameter TAG_DEPTH, default 4: tag FIFO entries, a power of two, at least 2.
REQ-004 The block SHALL have these clock and reset ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have these Y input ports:
- y_valid  in  1  Y block offered.
- y_ready  out  1  Y block accepted.
- y_block  in  DATA_WIDTH*PIXEL_COUNT  Y samples.
REQ-006 The block SHALL have ports cb_valid, cb_ready, cb_block, cr_valid, cr_ready and cr_block, identical to REQ-005 for Cb and Cr.
REQ-007 The block SHALL have these shared-DCT input ports:
- dct_in_valid  out  1
- dct_in_ready  in  1
- dct_in_block  out  DATA_WIDTH*PIXEL_COUNT
REQ-008 The block SHALL have these shared-DCT result ports:
- dct_out_valid  in  1
- dct_out_ready  out  1
- dct_out_block  in  DATA_WIDTH*PIXEL_COUNT
REQ-009 The block SHALL have these downstream ports:
- out_valid  out  1
- out_ready  in  1
- out_block  out  DATA_WIDTH*PIXEL_COUNT
- out_chan  out  2  0=Y, 1=Cb, 2=Cr.
REQ-010 The block SHALL have these status ports:
- mcu_count  out  16  count of completed Y,Cb,Cr triples issued.
- protocol_err  out  1  sticky error flag.

Function
REQ-011 The block SHALL time-share one DCT pipeline among Y, Cb and Cr in strict MCU order Y->Cb->Cr->Y, using FSM states SEL_Y, SEL_CB and SEL_CR.
REQ-012 dct_in_block SHALL be the block of the selected channel, muxed combinationally.
REQ-013 dct_in_valid SHALL equal selected_valid AND NOT tag_full.
REQ-014 The selected channel's ready SHALL equal dct_in_ready AND NOT tag_full; the other two readys SHALL be 0.
REQ-015 An issue SHALL be the condition dct_in_valid AND dct_in_ready; on an issue the block SHALL push the channel code into the tag FIFO and advance the FSM to the next state.
REQ-016 Without an issue, the FSM SHALL hold its state and SHALL NOT skip an idle channel.
REQ-017 On the issue from SEL_CR, mcu_count SHALL increment; it SHALL wrap from 0xFFFF to 0.
REQ-018 The return path SHALL be zero-latency:
- out_valid = dct_out_valid, out_block = dct_out_block, dct_out_ready = out_ready.
- out_chan = tag FIFO head.
REQ-019 A transfer (dct_out_valid AND out_ready) SHALL pop the tag FIFO.
REQ-020 When the tag FIFO is full, the block SHALL block issue even if a pop occurs in the same cycle; the full flag SHALL be registered.
REQ-021 A push and a pop in the same cycle with the FIFO non-empty and non-full SHALL leave the occupancy unchanged.
REQ-022 dct_out_valid=1 while the tag FIFO is empty SHALL set protocol_err and SHALL NOT pop; out_chan SHALL read 3 in that case.
REQ-023 protocol_err SHALL clear only on reset.
REQ-024 The block SHALL hold all input and output valid/data pairs stable semantics: it SHALL never drop an offered block and SHALL never reorder blocks.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL set:
- FSM to SEL_Y.
- Tag FIFO to empty.
- mcu_count to 0.
- protocol_err to 0.
REQ-026 While reset=1, the block SHALL drive y_ready, cb_ready, cr_ready and dct_in_valid to 0.
REQ-027 A reset asserted mid-operation SHALL discard all outstanding tags; the integration SHALL reset the shared DCT with the same reset.

Configuration
REQ-028 With macro JPEG_SCHED_STALL_CNT_EN defined, the block SHALL add output stall_count (32 bits), reset to 0.
REQ-029 stall_count SHALL increment on each cycle where selected_valid=1 and no issue occurs, and SHALL saturate at 0xFFFFFFFF.
REQ-030 Without JPEG_SCHED_STALL_CNT_EN, the stall_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover in-order issue:
- Stimulus: y, cb and cr all valid, dct_in_ready=1.
- Response: issues Y, Cb, Cr on consecutive cycles; mcu_count=1 after cycle 3.
REQ-032 The bench SHALL cover strict ordering:
- Stimulus: only cb_valid=1 after reset.
- Response: no issue, cb_ready=0, FSM stays SEL_Y; with stall counting enabled, stall_count=0.
REQ-033 The bench SHALL cover tag FIFO full:
- Stimulus: TAG_DEPTH=4, out_ready=0, results held.
- Response: after 4 issues, dct_in_valid=0 and all readys=0; one pop re-enables issue the next cycle.
REQ-034 The bench SHALL cover tag return:
- Stimulus: DCT returns 3 results in order.
- Response: out_chan sequence 0,1,2, each matching its issued block.
- Stimulus: a spurious dct_out_valid with the FIFO empty.
- Response: protocol_err=1 and it stays set.
REQ-035 The bench SHALL cover reset mid-operation:
- Stimulus: reset with 2 tags outstanding and FSM in SEL_CR.
- Response: next cycle FSM in SEL_Y, FIFO empty, mcu_count=0.
REQ-036 The bench SHALL cover counter wrap:
- Stimulus: force 65536 MCUs (or preload).
- Response: mcu_count wraps to 0.
